// File: rtl/aig_exhaustive_response_collector.sv
`default_nettype none
// ============================================================================
// Module   : aig_exhaustive_response_collector
// Purpose  : Sweeps every N_IN-bit input vector into a small combinational
//            benchmark netlist and compacts the responses into a MISR
//            signature plus a per-output count of 1s. The results label the
//            benchmark circuit for the dataset host.
// Ports    : clk      - single clock, rising edge
//            rst      - synchronous, active-high reset
//            start_i  - one-cycle request to begin a sweep (IDLE only)
//            vec_o    - registered vector to the benchmark (x0 = bit 0)
//            resp_i   - benchmark outputs (f1 = bit 0)
//            busy_o   - high while a sweep is active
//            done_o   - one-cycle pulse when sig_o/ones_o are final
//            sig_o    - final MISR signature, held until the next sweep ends
//            ones_o   - per-output 1s count, field k = output k, N_IN+1 bits
// Revision : 1.0 - initial release
// ============================================================================
module aig_exhaustive_response_collector #(
    parameter int                 N_IN     = 7,
    parameter int                 N_OUT    = 4,
    parameter int                 SIG_W    = 16,
    parameter logic [SIG_W-1:0]   POLY     = 16'h1021,
    parameter logic [SIG_W-1:0]   SEED     = 16'hFFFF,
    parameter int                 RESP_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    output logic [N_IN-1:0]             vec_o,
    input  logic [N_OUT-1:0]            resp_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [SIG_W-1:0]            sig_o,
    output logic [N_OUT*(N_IN+1)-1:0]   ones_o
);

    localparam logic [1:0]      c_ST_IDLE  = 2'd0;
    localparam logic [1:0]      c_ST_RUN   = 2'd1;
    localparam logic [1:0]      c_ST_DRAIN = 2'd2;
    localparam logic [1:0]      c_ST_DONE  = 2'd3;

    localparam logic [N_IN-1:0] c_VEC_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [N_IN-1:0] c_VEC_LAST = {N_IN{1'b1}};
    localparam logic [N_IN:0]   c_CNT_ONE  = {{N_IN{1'b0}}, 1'b1};

    logic [1:0]                     r_state;
    logic [1:0]                     w_next_state;
    logic [N_IN-1:0]                r_vec;
    logic [RESP_LAT-1:0]            r_tag;
    logic [RESP_LAT-1:0]            w_tag_next;
    logic [RESP_LAT:0]              w_tag_ext;
    logic [SIG_W-1:0]               r_misr;
    logic [SIG_W-1:0]               w_misr_next;
    logic [SIG_W-1:0]               w_resp_ext;
    logic [N_OUT-1:0][N_IN:0]       r_cnt;
    logic [SIG_W-1:0]               r_sig;
    logic [N_OUT-1:0][N_IN:0]       r_ones;
    logic                           w_launch;
    logic                           w_sample;
    logic                           w_accept;

    // A new vector is placed on vec_o on the accepting start edge and on
    // every RUN edge; each such edge injects a valid tag into the pipe, and
    // the response is sampled when that tag reaches the last stage.
    assign w_accept = (r_state == c_ST_IDLE) && start_i;
    assign w_launch = w_accept || (r_state == c_ST_RUN);
    assign w_sample = r_tag[RESP_LAT-1];

    always_comb begin
        w_tag_ext  = {r_tag, w_launch};
        w_tag_next = w_tag_ext[RESP_LAT-1:0];
    end

    always_comb begin
        w_resp_ext              = '0;
        w_resp_ext[N_OUT-1:0]   = resp_i;
        w_misr_next = {r_misr[SIG_W-2:0], 1'b0}
                    ^ (r_misr[SIG_W-1] ? POLY : {SIG_W{1'b0}})
                    ^ w_resp_ext;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start_i) begin
                    w_next_state = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                // This edge drives the last vector onto vec_o.
                if (r_vec == (c_VEC_LAST - c_VEC_ONE)) begin
                    w_next_state = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                // Pipe empty means the last vector's response is in the MISR.
                if (r_tag == '0) begin
                    w_next_state = c_ST_DONE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_vec   <= '0;
            r_tag   <= '0;
            r_misr  <= '0;
            r_cnt   <= '0;
            r_sig   <= '0;
            r_ones  <= '0;
        end else begin
            r_state <= w_next_state;
            r_tag   <= w_tag_next;
            if (w_accept) begin
                r_vec  <= '0;
                r_misr <= SEED;
                r_cnt  <= '0;
            end else begin
                if (r_state == c_ST_RUN) begin
                    r_vec <= r_vec + c_VEC_ONE;
                end
                if (w_sample) begin
                    r_misr <= w_misr_next;
                    for (int k = 0; k < N_OUT; k++) begin
                        if (resp_i[k]) begin
                            r_cnt[k] <= r_cnt[k] + c_CNT_ONE;
                        end
                    end
                end
            end
            // Published results change only when the sweep completes.
            if ((r_state == c_ST_DRAIN) && (w_next_state == c_ST_DONE)) begin
                r_sig  <= r_misr;
                r_ones <= r_cnt;
            end
        end
    end

    assign vec_o  = r_vec;
    assign busy_o = (r_state != c_ST_IDLE);
    assign done_o = (r_state == c_ST_DONE);
    assign sig_o  = r_sig;
    assign ones_o = r_ones;

endmodule
`default_nettype wire
